serial_nor_adder: RTL
=====================

Name: serial_nor_adder

Overview:
- Parametrised bit-serial add/subtract unit for the memristor-logic flow.
- Each bit is evaluated by a NOR/NOT-only full-adder cell, mirroring MAGIC in-array evaluation order: one bit per cycle, LSB first.
- Successor to the NOR/NOT half adder: generalised to WIDTH bits, with carry-in, subtract mode, overflow and a start/busy/done handshake.
- Sits between the operand staging registers and the result writeback of the in-memory compute datapath.

Parameters:
- WIDTH, 8, operand/result width in bits; legal range >= 2.
- CNT_W, $clog2(WIDTH), bit counter width; derived, not overridden.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request; sampled only when not busy.
- mode  input  1  0 = add (a+b), 1 = subtract (a-b); sampled with start.
- a  input  WIDTH  operand A; sampled with start.
- b  input  WIDTH  operand B; sampled with start.
- busy  output  1  high while bits are being evaluated.
- done  output  1  one-cycle pulse; result valid.
- sum  output  WIDTH  result; held until the next completion.
- cout  output  1  carry out of the MSB (subtract: 1 = no borrow).
- ovf  output  1  signed overflow.

Behaviour:
- Reset (rst=1 at a rising edge):
  - state = IDLE.
  - busy, done, sum, cout, ovf all = 0.
  - Internal shift registers, carry and counter cleared.
  - Applies in any state; an in-flight operation is abandoned and no done is produced.
- States: IDLE, RUN, DONE.
- IDLE, start=1: load areg=a, breg = mode ? ~b : b, carry = mode, cnt=0, go RUN.
- IDLE, start=0: stay in IDLE.
- RUN, each cycle:
  - nor_full_adder evaluates (areg[0], breg[0], carry).
  - Sum bit shifts into sreg from the MSB side; areg and breg shift right; carry takes the cell carry-out; cnt++.
  - When cnt == WIDTH-1 (last bit): latch ovf = carry_in_to_this_bit XOR cell_cout, then go DONE.
- DONE, for one cycle:
  - done=1; sum=sreg, cout=carry, ovf as latched.
  - Outputs update on the edge entering DONE and then hold.
  - start=1 in DONE is accepted (back-to-back): same load as IDLE, next state RUN. Otherwise next state IDLE.
- busy=1 exactly in RUN. start while busy is ignored, not queued.
- Latency: start sampled at edge E, done high in the cycle after edge E+WIDTH. Throughput is one result per WIDTH+1 cycles.
- sum, cout and ovf change only on entry to DONE or on reset. They do not change during RUN.
- Arithmetic is modulo 2^WIDTH. Operands are treated as two's complement for ovf only.
- a, b and mode changing during RUN have no effect.

Decomposition:
- Package serial_nor_pkg:
  - State enum: IDLE=2'd0, RUN=2'd1, DONE=2'd2.
  - Mode constants MODE_ADD=1'b0, MODE_SUB=1'b1.
- Sub-module nor_full_adder (combinational): ports x, y, ci -> s, co. Built strictly from nor/not gate primitives, no behavioural operators.
- Top level holds the FSM, counter and shift registers only.

Test Plan (WIDTH=8):
- add a=0x35, b=0x4A -> done after 9 cycles, sum=0x7F, cout=0, ovf=0; busy high 8 cycles.
- add a=0xFF, b=0x01 -> sum=0x00, cout=1, ovf=0. Then add a=0x7F, b=0x01 -> sum=0x80, cout=0, ovf=1.
- sub a=0x10, b=0x20 -> sum=0xF0, cout=0, ovf=0. sub a=0x80, b=0x01 -> sum=0x7F, cout=1, ovf=1.
- start pulsed with a=0x01,b=0x01 during RUN of a 0x35+0x4A op -> ignored; only 0x7F result; a single done pulse.
- rst asserted at the 4th RUN cycle -> next cycle busy=0, sum/cout/ovf=0. No done for 10 cycles unless a new start is given.
- start held high continuously with 0x01+0x02 then 0x03+0x04 presented at the DONE cycle -> done pulses every 9 cycles, sums 0x03 then 0x07; busy low only in DONE cycles.

Source files
------------

// File: rtl/serial_nor_pkg.sv
// Shared types and constants for the bit-serial NOR-logic add/subtract unit.
package serial_nor_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic MODE_ADD = 1'b0;
  localparam logic MODE_SUB = 1'b1;

endpackage

// File: rtl/serial_nor_adder_nor_full_adder.sv
// One-bit full adder built only from NOR/NOT gates, matching the in-array
// MAGIC evaluation primitives.
module nor_full_adder (
  input  logic x,
  input  logic y,
  input  logic ci,
  output logic s,
  output logic co
);

  logic w_nxy, w_xny, w_nxy2, w_xnor_xy, w_xor_xy;
  logic w_m1, w_m2, w_m3, w_sn;
  logic w_nx, w_ny, w_nci, w_and_xy, w_and_cx, w_nco;

  // x XOR y via four NORs and an inverter
  nor g_n1 (w_nxy,     x,     y);
  nor g_n2 (w_xny,     x,     w_nxy);
  nor g_n3 (w_nxy2,    y,     w_nxy);
  nor g_n4 (w_xnor_xy, w_xny, w_nxy2);
  not g_i1 (w_xor_xy,  w_xnor_xy);

  // (x XOR y) XOR ci with the same structure
  nor g_n5 (w_m1, w_xor_xy, ci);
  nor g_n6 (w_m2, w_xor_xy, w_m1);
  nor g_n7 (w_m3, ci,       w_m1);
  nor g_n8 (w_sn, w_m2,     w_m3);
  not g_i2 (s,    w_sn);

  // co = (x & y) | (ci & (x XOR y)); ANDs formed as NOR of complements
  not g_i3 (w_nx,     x);
  not g_i4 (w_ny,     y);
  not g_i5 (w_nci,    ci);
  nor g_n9 (w_and_xy, w_nx,  w_ny);
  nor g_na (w_and_cx, w_nci, w_xnor_xy);
  nor g_nb (w_nco,    w_and_xy, w_and_cx);
  not g_i6 (co,       w_nco);

endmodule

// File: rtl/serial_nor_adder.sv
// Bit-serial add/subtract, LSB first, one NOR full-adder evaluation per cycle,
// with start/busy/done handshake and registered result/carry/overflow.
module serial_nor_adder
  import serial_nor_pkg::*;
#(
  parameter  int unsigned WIDTH = 8,
  localparam int unsigned CNT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  state_t           r_state;
  logic [WIDTH-1:0] r_areg;
  logic [WIDTH-1:0] r_breg;
  logic [WIDTH-1:0] r_sreg;
  logic             r_carry;
  logic [CNT_W-1:0] r_cnt;

  logic             w_s;
  logic             w_co;

  nor_full_adder u_fa (
    .x  (r_areg[0]),
    .y  (r_breg[0]),
    .ci (r_carry),
    .s  (w_s),
    .co (w_co)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_areg  <= '0;
      r_breg  <= '0;
      r_sreg  <= '0;
      r_carry <= 1'b0;
      r_cnt   <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      sum     <= '0;
      cout    <= 1'b0;
      ovf     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (r_state)
        IDLE, DONE: begin
          // DONE accepts a new start just like IDLE, giving back-to-back ops
          if (start) begin
            r_areg  <= a;
            r_breg  <= (mode == MODE_ADD) ? b : ~b;
            r_carry <= (mode == MODE_SUB);
            r_sreg  <= '0;
            r_cnt   <= '0;
            busy    <= 1'b1;
            r_state <= RUN;
          end else begin
            r_state <= IDLE;
          end
        end
        RUN: begin
          r_areg  <= r_areg >> 1;
          r_breg  <= r_breg >> 1;
          r_sreg  <= {w_s, r_sreg[WIDTH-1:1]};
          r_carry <= w_co;
          r_cnt   <= r_cnt + CNT_W'(1);
          if (r_cnt == LAST) begin
            // r_carry here is the carry into the MSB cell
            sum     <= {w_s, r_sreg[WIDTH-1:1]};
            cout    <= w_co;
            ovf     <= r_carry ^ w_co;
            done    <= 1'b1;
            busy    <= 1'b0;
            r_state <= DONE;
          end
        end
        default: begin
          busy    <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule
